// File: rtl/instr_exec_sequencer.sv
// Multi-cycle sequencer: accepts one instruction, holds it for the decoder, runs the external ALU,
// then writes the result back or reports an illegal opcode / ALU timeout. All outputs registered.
module instr_exec_sequencer #(
  parameter int unsigned ALU_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  output logic [31:0]      dec_instr,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [31:0]      alu_result,
  output logic             we,
  output logic [4:0]       wb_addr,
  output logic [31:0]      wb_data,
  output logic             busy,
  output logic             hata,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned TW = $clog2(ALU_TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StDecode, StExec, StWb, StErr} state_e;

  state_e        state;
  logic [TW-1:0] exec_cnt;
  logic          is_b;
  logic [4:0]    rd;

  assign rd = dec_instr[11:7];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      dec_instr   <= '0;
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      alu_start   <= 1'b0;
      we          <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
      hata        <= 1'b0;
      err_code    <= 2'd0;
      retired_cnt <= '0;
      err_cnt     <= '0;
      exec_cnt    <= '0;
      is_b        <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      we        <= 1'b0;
      hata      <= 1'b0;
      unique case (state)
        StIdle: begin
          if (instr_valid) begin
            dec_instr   <= instr;
            state       <= StDecode;
            instr_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        StDecode: begin
          unique case (dec_instr[6:0])
            7'b0000001, 7'b0000011, 7'b0000111, 7'b0001111: begin
              is_b      <= (dec_instr[6:0] == 7'b0001111);
              state     <= StExec;
              alu_start <= 1'b1;
              exec_cnt  <= TW'(1);
            end
            default: begin
              state    <= StErr;
              hata     <= 1'b1;
              err_code <= 2'd1;
              if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end
          endcase
        end
        StExec: begin
          // done wins over a timeout reached in the same cycle
          if (alu_done) begin
            wb_data <= alu_result;
            wb_addr <= rd;
            we      <= !is_b && (rd != 5'd0);
            state   <= StWb;
            if (retired_cnt != '1) retired_cnt <= retired_cnt + 1'b1;
          end else if (exec_cnt == TW'(ALU_TIMEOUT)) begin
            state    <= StErr;
            hata     <= 1'b1;
            err_code <= 2'd2;
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          end else begin
            exec_cnt <= exec_cnt + 1'b1;
          end
        end
        StWb, StErr: begin
          state       <= StIdle;
          instr_ready <= 1'b1;
          busy        <= 1'b0;
        end
        default: begin
          state       <= StIdle;
          instr_ready <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_exec_sequencer.sv
// Directed self-checking bench for instr_exec_sequencer with ALU_TIMEOUT = 4.
module tb_instr_exec_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] dec_instr;
  logic        alu_start;
  logic        alu_done;
  logic [31:0] alu_result;
  logic        we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        busy;
  logic        hata;
  logic [1:0]  err_code;
  logic [15:0] retired_cnt;
  logic [15:0] err_cnt;

  int total = 0;
  int bad   = 0;

  instr_exec_sequencer #(
    .ALU_TIMEOUT(4),
    .CNT_W      (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_ready(instr_ready),
    .dec_instr  (dec_instr),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .we         (we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .busy       (busy),
    .hata       (hata),
    .err_code   (err_code),
    .retired_cnt(retired_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; instr_valid = 1'b0; instr = '0; alu_done = 1'b0; alu_result = '0;
    step(); step();
    reset = 1'b0;
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got %b want 1", instr_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
    total++; if (dec_instr !== 32'h0) begin bad++; $display("FAIL rst_dec got %h want 0", dec_instr); end
    total++; if ({we, alu_start, hata} !== 3'b000) begin bad++; $display("FAIL rst_pulses got %b want 000", {we, alu_start, hata}); end
    total++; if ({wb_addr, wb_data} !== 37'h0) begin bad++; $display("FAIL rst_wb got %h/%h want 0/0", wb_addr, wb_data); end
    total++; if (err_code !== 2'd0) begin bad++; $display("FAIL rst_errcode got %0d want 0", err_code); end
    total++; if ({retired_cnt, err_cnt} !== 32'h0) begin bad++; $display("FAIL rst_cnts got %0d/%0d want 0/0", retired_cnt, err_cnt); end
  endtask

  task automatic test_r_type();
    instr_valid = 1'b1; instr = 32'h00208281;
    step();  // DECODE
    instr_valid = 1'b0;
    total++; if (dec_instr !== 32'h00208281) begin bad++; $display("FAIL r_dec got %h want 00208281", dec_instr); end
    total++; if ({instr_ready, busy, alu_start} !== 3'b010) begin bad++; $display("FAIL r_decode got %b want 010", {instr_ready, busy, alu_start}); end
    step();  // EXEC 1
    total++; if (alu_start !== 1'b1) begin bad++; $display("FAIL r_start got %b want 1", alu_start); end
    alu_done = 1'b1; alu_result = 32'hDEADBEEF;
    step();  // WB
    alu_done = 1'b0;
    total++; if ({we, alu_start} !== 2'b10) begin bad++; $display("FAIL r_we got %b want 10", {we, alu_start}); end
    total++; if (wb_addr !== 5'd5) begin bad++; $display("FAIL r_addr got %0d want 5", wb_addr); end
    total++; if (wb_data !== 32'hDEADBEEF) begin bad++; $display("FAIL r_data got %h want deadbeef", wb_data); end
    total++; if (retired_cnt !== 16'd1) begin bad++; $display("FAIL r_retired got %0d want 1", retired_cnt); end
    step();  // IDLE
    total++; if ({instr_ready, busy, we} !== 3'b100) begin bad++; $display("FAIL r_idle got %b want 100", {instr_ready, busy, we}); end
  endtask

  task automatic test_i_rd0();
    instr_valid = 1'b1; instr = 32'h00500003;
    step(); instr_valid = 1'b0;  // DECODE
    step();                      // EXEC 1
    total++; if (alu_start !== 1'b1) begin bad++; $display("FAIL i_start got %b want 1", alu_start); end
    step();                      // EXEC 2
    total++; if ({alu_start, busy} !== 2'b01) begin bad++; $display("FAIL i_exec2 got %b want 01", {alu_start, busy}); end
    step();                      // EXEC 3
    alu_done = 1'b1; alu_result = 32'h12345678;
    step();                      // WB
    alu_done = 1'b0;
    total++; if ({we, hata, busy} !== 3'b001) begin bad++; $display("FAIL i_wb got %b want 001", {we, hata, busy}); end
    total++; if (retired_cnt !== 16'd2) begin bad++; $display("FAIL i_retired got %0d want 2", retired_cnt); end
    step();
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL i_idle got %b want 1", instr_ready); end
  endtask

  task automatic test_illegal();
    instr_valid = 1'b1; instr = 32'h00000033;
    step(); instr_valid = 1'b0;  // DECODE
    total++; if (hata !== 1'b0) begin bad++; $display("FAIL ill_early got %b want 0", hata); end
    step();                      // ERR
    total++; if ({hata, alu_start} !== 2'b10) begin bad++; $display("FAIL ill_hata got %b want 10", {hata, alu_start}); end
    total++; if (err_code !== 2'd1) begin bad++; $display("FAIL ill_code got %0d want 1", err_code); end
    total++; if (err_cnt !== 16'd1) begin bad++; $display("FAIL ill_errcnt got %0d want 1", err_cnt); end
    total++; if (retired_cnt !== 16'd2) begin bad++; $display("FAIL ill_retired got %0d want 2", retired_cnt); end
    step();                      // IDLE
    total++; if ({hata, instr_ready} !== 2'b01) begin bad++; $display("FAIL ill_idle got %b want 01", {hata, instr_ready}); end
    total++; if (err_code !== 2'd1) begin bad++; $display("FAIL ill_hold got %0d want 1", err_code); end
  endtask

  task automatic test_timeout();
    instr_valid = 1'b1; instr = 32'h0000000F;
    step(); instr_valid = 1'b0;  // DECODE
    step();                      // EXEC 1
    for (int i = 2; i <= 4; i++) begin
      step();                    // EXEC i
      total++; if ({hata, we, busy} !== 3'b001) begin bad++; $display("FAIL to_exec%0d got %b want 001", i, {hata, we, busy}); end
    end
    step();                      // ERR
    total++; if ({hata, we} !== 2'b10) begin bad++; $display("FAIL to_hata got %b want 10", {hata, we}); end
    total++; if (err_code !== 2'd2) begin bad++; $display("FAIL to_code got %0d want 2", err_code); end
    total++; if (err_cnt !== 16'd2) begin bad++; $display("FAIL to_errcnt got %0d want 2", err_cnt); end
    step();
  endtask

  task automatic test_done_at_limit();
    instr_valid = 1'b1; instr = 32'h0000008F;
    step(); instr_valid = 1'b0;  // DECODE
    step(); step(); step(); step();  // EXEC 4
    alu_done = 1'b1; alu_result = 32'hCAFE0001;
    step();                      // WB
    alu_done = 1'b0;
    total++; if ({we, hata, busy} !== 3'b001) begin bad++; $display("FAIL lim_wb got %b want 001", {we, hata, busy}); end
    total++; if (wb_data !== 32'hCAFE0001) begin bad++; $display("FAIL lim_data got %h want cafe0001", wb_data); end
    total++; if ({retired_cnt, err_cnt} !== {16'd3, 16'd2}) begin bad++; $display("FAIL lim_cnts got %0d/%0d want 3/2", retired_cnt, err_cnt); end
    total++; if (err_code !== 2'd2) begin bad++; $display("FAIL lim_code got %0d want 2", err_code); end
    step();
  endtask

  task automatic test_reset_mid_exec();
    instr_valid = 1'b1; instr = 32'h00208281;
    step(); instr_valid = 1'b0;  // DECODE
    step(); step();              // EXEC 2
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if ({instr_ready, busy, we} !== 3'b100) begin bad++; $display("FAIL mid_idle got %b want 100", {instr_ready, busy, we}); end
    total++; if ({retired_cnt, err_cnt} !== 32'h0) begin bad++; $display("FAIL mid_cnts got %0d/%0d want 0/0", retired_cnt, err_cnt); end
    total++; if ({err_code, dec_instr} !== 34'h0) begin bad++; $display("FAIL mid_regs got %0d/%h want 0/0", err_code, dec_instr); end
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    total++; if ({we, busy, instr_ready} !== 3'b001) begin bad++; $display("FAIL mid_late got %b want 001", {we, busy, instr_ready}); end
    total++; if (retired_cnt !== 16'd0) begin bad++; $display("FAIL mid_retired got %0d want 0", retired_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] list [3];
    logic [31:0] last;
    int idx;
    int we_seen;
    logic acc;
    list[0] = 32'h00000081; list[1] = 32'h00000101; list[2] = 32'h00000181;
    idx = 0; we_seen = 0; last = dec_instr;
    alu_done = 1'b1; alu_result = 32'h55AA55AA;
    instr_valid = 1'b1; instr = list[0];
    for (int c = 0; c < 12; c++) begin
      acc = instr_ready && instr_valid;
      total++; if (instr_ready !== (c % 4 == 0)) begin bad++; $display("FAIL b2b_ready c%0d got %b want %b", c, instr_ready, (c % 4 == 0)); end
      step();
      if (acc) begin
        last = list[idx];
        idx++;
        if (idx < 3) instr = list[idx];
        else instr_valid = 1'b0;
      end
      if (we) we_seen++;
      total++; if (dec_instr !== last) begin bad++; $display("FAIL b2b_dec c%0d got %h want %h", c, dec_instr, last); end
    end
    alu_done = 1'b0;
    total++; if (idx !== 3) begin bad++; $display("FAIL b2b_accepts got %0d want 3", idx); end
    total++; if (we_seen !== 3) begin bad++; $display("FAIL b2b_we got %0d want 3", we_seen); end
    total++; if (retired_cnt !== 16'd3) begin bad++; $display("FAIL b2b_retired got %0d want 3", retired_cnt); end
    total++; if (wb_addr !== 5'd3) begin bad++; $display("FAIL b2b_addr got %0d want 3", wb_addr); end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_i_rd0();
    test_illegal();
    test_timeout();
    test_done_at_limit();
    test_reset_mid_exec();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_exec_sequencer.md
Name: instr_exec_sequencer

Overview:
- Multi-cycle control FSM that sequences the instruction decoder and the two-read/one-write register file.
- Accepts one 32-bit instruction at a time over a valid/ready handshake and holds it stable for the decoder.
- Starts the external ALU, waits for its completion, and drives the register-file write port.
- Classifies opcodes (R/I/U/B), reports illegal opcodes and ALU timeouts, and keeps retire/error statistics.

Parameters:
ALU_TIMEOUT, 16, max EXEC cycles waiting for alu_done before a timeout error (>=1)
CNT_W, 16, width of retired_cnt and err_cnt (saturating)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
instr_valid  input  1  upstream has an instruction
instr  input  32  instruction word; opcode = instr[6:0], rd = instr[11:7]
instr_ready  output  1  sequencer can accept an instruction
dec_instr  output  32  latched instruction driven to the decoder
alu_start  output  1  one-cycle pulse to start the ALU
alu_done  input  1  ALU result valid
alu_result  input  32  ALU result
we  output  1  register-file write enable
wb_addr  output  5  register-file write address
wb_data  output  32  register-file write data
busy  output  1  high in any state except IDLE
hata  output  1  one-cycle error pulse
err_code  output  2  0 none, 1 illegal opcode, 2 ALU timeout; held until the next error or reset
retired_cnt  output  CNT_W  instructions completed without error
err_cnt  output  CNT_W  errors reported

Behaviour:
- Reset (synchronous, priority over everything):
  - State = IDLE; dec_instr = 0; we = 0; wb_addr = 0; wb_data = 0; alu_start = 0; hata = 0; err_code = 0; both counters = 0.
  - Reset asserted mid-operation abandons the instruction. No write occurs in the cycle after reset.
- States: IDLE, DECODE, EXEC, WB, ERR. All outputs are registered.
- IDLE:
  - instr_ready = 1.
  - instr_valid = 1 → latch instr into dec_instr, go to DECODE (cycle 0 = accept).
  - instr_ready = 0 in every other state; instr is ignored there.
- DECODE (1 cycle), opcode classes:
  - 0000001 (R), 0000011 (I), 0000111 (U), 0001111 (B) → EXEC.
  - Any other opcode → ERR with err_code = 1. No alu_start is issued.
- EXEC:
  - alu_start = 1 only on the first EXEC cycle.
  - alu_done is sampled from that same cycle on, so a zero-wait ALU is legal. alu_done outside EXEC is ignored.
  - On alu_done: capture alu_result into wb_data and rd into wb_addr, go to WB.
  - An internal counter counts EXEC cycles. After ALU_TIMEOUT cycles without alu_done → ERR with err_code = 2.
  - alu_done arriving on the cycle the counter reaches ALU_TIMEOUT counts as done (done wins).
- WB (1 cycle):
  - we = 1 only if the class is R/I/U and wb_addr != 0.
  - B class, or rd = 0: we = 0 (x0 write-protected).
  - retired_cnt increments (saturates at all-ones). Next state is IDLE.
- ERR (1 cycle): hata = 1, err_cnt increments (saturating), next state IDLE.
- Throughput and latency:
  - Minimum 4 cycles per instruction (accept, DECODE, EXEC with immediate done, WB).
  - IDLE can re-accept in the cycle after WB or ERR.
  - we asserts exactly 3 cycles after accept when alu_done is immediate.
- Other output rules:
  - dec_instr holds its value from accept until the next accept.
  - we and alu_start are never high for more than one consecutive cycle.
  - busy = 1 whenever state != IDLE.

Test Plan:
- R-type, zero-wait ALU: instr = 0x00208281 (rd = 5) accepted; alu_done = 1 with alu_result = 0xDEADBEEF in the first EXEC cycle → alu_start pulses once; we = 1, wb_addr = 5, wb_data = 0xDEADBEEF exactly 3 cycles after accept; retired_cnt = 1; instr_ready back to 1 the next cycle.
- I-type with rd = 0: instr = 0x00500003, alu_done after 3 cycles → WB visited with we = 0; retired_cnt increments; hata stays 0.
- Illegal opcode: instr = 0x00000033 → no alu_start; hata pulses 2 cycles after accept; err_code = 1; err_cnt = 1; retired_cnt unchanged.
- ALU timeout with ALU_TIMEOUT = 4: B-type instr = 0x0000000F, alu_done held 0 → ERR after 4 EXEC cycles; err_code = 2; we never asserted.
  - Repeat with alu_done on the 4th EXEC cycle → WB with we = 0; no error.
- Reset mid-EXEC: assert reset during the 2nd EXEC cycle → next cycle state IDLE, instr_ready = 1, all counters 0, we = 0; a late alu_done pulse is ignored.
- Back-to-back: instr_valid held high with 3 R-type instructions → exactly 3 accepts, one per 4 cycles; dec_instr changes only on accept; retired_cnt = 3.
